calc_op_sequencer: RTL and testbench

//  Sequences one ALU operation per debounced "go" press on the calculator board.

---
 rtl/calc_pkg.sv | 30 +++
 rtl/btn_debounce.sv | 46 ++++
 rtl/calc_op_sequencer.sv | 165 ++++++++++++++++
 tb/tb_calc_op_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator operation sequencer and its ALU.
//   DATA_W    : operand / result width
//   state_t   : sequencer state encoding
//   alu_req_t : operand/opcode payload presented to the ALU
//   OP_*      : opcode values understood by the ALU
package calc_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned OP_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_LATCH = 2'd2,
    ST_SHOW  = 2'd3
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   opcode;
  } alu_req_t;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_AND = 4'd2;
  localparam logic [OP_W-1:0] OP_OR  = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR = 4'd4;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, rising-edge pulse.
//   clock, reset : system clock, synchronous active-low reset
//   btn          : raw asynchronous bouncy button
//   pulse        : one-cycle pulse when the debounced level goes 0->1
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // The synced level must differ from the accepted level for DEBOUNCE_CYCLES
  // consecutive cycles before it is accepted; any return restarts the count.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync2;
        cnt    <= '0;
        pulse  <= sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/calc_op_sequencer.sv
// Sequences one ALU operation per debounced go press and holds the result for display.
//   clock, reset              : system clock, synchronous active-low reset
//   go_btn, clear_btn         : raw buttons (go debounced, clear synced only)
//   chain_en                  : take operand A from the accumulator when it is valid
//   A_sw, B_sw, Opcode_sw     : operand / opcode switches
//   alu_A, alu_B, alu_Opcode  : registered ALU inputs; alu_clr high in IDLE
//   alu_result, alu_overflow  : combinational ALU outputs
//   disp_value, disp_opcode   : latched result and its opcode
//   result_valid, err_flag    : result present / overflow indicator
//   busy                      : operation in flight (EXEC or LATCH)
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned EXEC_WAIT       = 2,
  parameter bit          STICKY_OVF      = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              go_btn,
  input  logic              clear_btn,
  input  logic              chain_en,
  input  logic [DATA_W-1:0] A_sw,
  input  logic [DATA_W-1:0] B_sw,
  input  logic [OP_W-1:0]   Opcode_sw,
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  output logic [OP_W-1:0]   alu_Opcode,
  output logic              alu_clr,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_overflow,
  output logic [DATA_W-1:0] disp_value,
  output logic [OP_W-1:0]   disp_opcode,
  output logic              result_valid,
  output logic              err_flag,
  output logic              busy
);

  localparam int unsigned WAIT_W = (EXEC_WAIT > 1) ? $clog2(EXEC_WAIT) : 1;

  state_t            state, state_nxt;
  logic              go_pulse;
  logic              clr_s1, clear;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  alu_req_t          req, req_nxt;
  logic [DATA_W-1:0] acc, acc_nxt;
  logic              acc_valid, acc_valid_nxt;
  logic [DATA_W-1:0] disp_value_nxt;
  logic [OP_W-1:0]   disp_opcode_nxt;
  logic              result_valid_nxt, err_flag_nxt, busy_nxt, alu_clr_nxt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_go_db (
    .clock (clock),
    .reset (reset),
    .btn   (go_btn),
    .pulse (go_pulse)
  );

  // clear is a level; synchronise only
  always_ff @(posedge clock) begin
    if (!reset) begin
      clr_s1 <= 1'b0;
      clear  <= 1'b0;
    end else begin
      clr_s1 <= clear_btn;
      clear  <= clr_s1;
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; clear overrides everything, including a coincident go
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (go_pulse) state_nxt = ST_EXEC;
        ST_EXEC:  if (wait_cnt == '0) state_nxt = ST_LATCH;
        ST_LATCH: state_nxt = ST_SHOW;
        ST_SHOW:  if (go_pulse) state_nxt = ST_EXEC;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    req_nxt          = req;
    wait_cnt_nxt     = wait_cnt;
    acc_nxt          = acc;
    acc_valid_nxt    = acc_valid;
    disp_value_nxt   = disp_value;
    disp_opcode_nxt  = disp_opcode;
    result_valid_nxt = result_valid;
    err_flag_nxt     = err_flag;
    if (clear) begin
      result_valid_nxt = 1'b0;
      acc_valid_nxt    = 1'b0;
      err_flag_nxt     = 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_SHOW: begin
          if (go_pulse) begin
            req_nxt.a      = (chain_en && acc_valid) ? acc : A_sw;
            req_nxt.b      = B_sw;
            req_nxt.opcode = Opcode_sw;
            wait_cnt_nxt   = WAIT_W'(EXEC_WAIT - 1);
          end
        end
        ST_EXEC: begin
          if (wait_cnt != '0) wait_cnt_nxt = wait_cnt - WAIT_W'(1);
        end
        ST_LATCH: begin
          disp_value_nxt   = alu_result;
          disp_opcode_nxt  = req.opcode;
          acc_nxt          = alu_result;
          acc_valid_nxt    = 1'b1;
          result_valid_nxt = 1'b1;
          err_flag_nxt     = STICKY_OVF ? (err_flag | alu_overflow) : alu_overflow;
        end
        default: ;
      endcase
    end
    busy_nxt    = (state_nxt == ST_EXEC) || (state_nxt == ST_LATCH);
    alu_clr_nxt = (state_nxt == ST_IDLE);
  end

  // Output / datapath registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      req          <= '0;
      wait_cnt     <= '0;
      acc          <= '0;
      acc_valid    <= 1'b0;
      disp_value   <= '0;
      disp_opcode  <= '0;
      result_valid <= 1'b0;
      err_flag     <= 1'b0;
      busy         <= 1'b0;
      alu_clr      <= 1'b1;
    end else begin
      req          <= req_nxt;
      wait_cnt     <= wait_cnt_nxt;
      acc          <= acc_nxt;
      acc_valid    <= acc_valid_nxt;
      disp_value   <= disp_value_nxt;
      disp_opcode  <= disp_opcode_nxt;
      result_valid <= result_valid_nxt;
      err_flag     <= err_flag_nxt;
      busy         <= busy_nxt;
      alu_clr      <= alu_clr_nxt;
    end
  end

  assign alu_A      = req.a;
  assign alu_B      = req.b;
  assign alu_Opcode = req.opcode;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Randomised and directed bench for calc_op_sequencer with an attached ALU model.
module tb_calc_op_sequencer;
  import calc_pkg::*;

  localparam int unsigned DEB = 8;
  localparam int unsigned EW  = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       go_btn = 1'b0, clear_btn = 1'b0, chain_en = 1'b0;
  logic [3:0] A_sw = '0, B_sw = '0, Opcode_sw = '0;
  logic [3:0] alu_A, alu_B, alu_Opcode, alu_result, disp_value, disp_opcode;
  logic       alu_clr, alu_overflow, result_valid, err_flag, busy;

  int total = 0;
  int bad   = 0;
  int pulse_cnt = 0;

  // reference state
  logic [3:0] m_acc = '0, m_disp = '0, m_dop = '0;
  bit         m_acc_valid = 0, m_rv = 0, m_err = 0;

  calc_op_sequencer #(.DEBOUNCE_CYCLES(DEB), .EXEC_WAIT(EW), .STICKY_OVF(1'b1)) dut (
    .clock(clock), .reset(reset), .go_btn(go_btn), .clear_btn(clear_btn),
    .chain_en(chain_en), .A_sw(A_sw), .B_sw(B_sw), .Opcode_sw(Opcode_sw),
    .alu_A(alu_A), .alu_B(alu_B), .alu_Opcode(alu_Opcode), .alu_clr(alu_clr),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .disp_value(disp_value), .disp_opcode(disp_opcode),
    .result_valid(result_valid), .err_flag(err_flag), .busy(busy)
  );

  always #5 clock = ~clock;

  // ALU: {overflow, result}
  function automatic logic [4:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] op);
    logic [4:0] s;
    case (op)
      OP_ADD:  s = {1'b0, a} + {1'b0, b};
      OP_SUB:  s = {(a < b), a - b};
      OP_AND:  s = {1'b0, a & b};
      OP_OR:   s = {1'b0, a | b};
      OP_XOR:  s = {1'b0, a ^ b};
      default: s = {1'b0, a};
    endcase
    return s;
  endfunction

  always_comb {alu_overflow, alu_result} = alu_ref(alu_A, alu_B, alu_Opcode);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (dut.u_go_db.pulse) pulse_cnt++;
  endtask

  task automatic wait_pulse(output bit seen);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (dut.u_go_db.pulse) seen = 1;
    end
  endtask

  task automatic model_clear();
    m_rv = 0; m_acc_valid = 0; m_err = 0;
  endtask

  task automatic check_held(input string tag);
    chk({tag, "_disp"}, 32'(disp_value), 32'(m_disp));
    chk({tag, "_dop"},  32'(disp_opcode), 32'(m_dop));
    chk({tag, "_rv"},   32'(result_valid), 32'(m_rv));
    chk({tag, "_err"},  32'(err_flag), 32'(m_err));
  endtask

  // Press go with given switches, follow the op through EXEC/LATCH, release.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                       input bit chain, input bit glitch);
    bit         seen;
    logic [3:0] ea;
    logic [4:0] r;
    int         p0;
    A_sw = a; B_sw = b; Opcode_sw = op; chain_en = chain;
    go_btn = 1'b1;
    wait_pulse(seen);
    chk("go_pulse_seen", 32'(seen), 32'd1);
    if (!seen) begin
      go_btn = 1'b0;
      return;
    end
    ea = (chain && m_acc_valid) ? m_acc : a;
    r  = alu_ref(ea, b, op);
    tick();
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_clr",  32'(alu_clr), 32'd0);
    chk("cap_A",     32'(alu_A), 32'(ea));
    chk("cap_B",     32'(alu_B), 32'(b));
    chk("cap_op",    32'(alu_Opcode), 32'(op));
    if (glitch) begin
      go_btn = 1'b0; tick(); go_btn = 1'b1;
    end else begin
      tick();
    end
    for (int i = 1; i < EW; i++) tick();
    chk("latch_busy", 32'(busy), 32'd1);
    check_held("pre_latch");
    tick();
    m_disp = r[3:0]; m_dop = op; m_acc = r[3:0]; m_acc_valid = 1; m_rv = 1;
    m_err = m_err | r[4];
    check_held("result");
    chk("show_busy", 32'(busy), 32'd0);
    p0 = pulse_cnt;
    go_btn = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    chk("no_extra_pulse", 32'(pulse_cnt - p0), 32'd0);
    chk("idle_after_busy", 32'(busy), 32'd0);
    check_held("after_release");
  endtask

  task automatic do_clear();
    clear_btn = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    clear_btn = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    model_clear();
    check_held("clear");
    chk("clear_alu_clr", 32'(alu_clr), 32'd1);
    chk("clear_busy",    32'(busy), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_A"},    32'(alu_A), 32'd0);
    chk({tag, "_B"},    32'(alu_B), 32'd0);
    chk({tag, "_op"},   32'(alu_Opcode), 32'd0);
    chk({tag, "_clr"},  32'(alu_clr), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    check_held(tag);
  endtask

  initial begin
    bit seen;
    int p0;
    // reset
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    check_reset_vals("reset");

    // 1: basic add
    do_op(4'd3, 4'd4, OP_ADD, 0, 0);
    // 2: wrap with sticky overflow, then clear
    do_op(4'd9, 4'd9, OP_ADD, 0, 0);
    do_op(4'd1, 4'd1, OP_ADD, 0, 0);
    chk("sticky_err", 32'(err_flag), 32'd1);
    do_clear();
    // 3: chain mode
    do_op(4'd3, 4'd4, OP_ADD, 0, 0);
    do_op(4'd0, 4'd2, OP_ADD, 1, 0);
    chk("chain_disp", 32'(disp_value), 32'd9);
    do_clear();
    do_op(4'd5, 4'd2, OP_ADD, 1, 0);
    chk("chain_after_clear", 32'(disp_value), 32'd7);

    // 4: bounce gives no pulse, the held press gives exactly one op
    p0 = pulse_cnt;
    for (int i = 0; i < 60; i++) begin
      go_btn = ((i / 3) % 2 == 0);
      tick();
    end
    chk("bounce_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    do_op(4'd6, 4'd2, OP_SUB, 0, 0);

    // 5a: go glitch during EXEC is ignored
    do_op(4'd12, 4'd10, OP_XOR, 0, 1);

    // 5b: clear held while the go pulse arrives
    clear_btn = 1'b1;
    A_sw = 4'd1; B_sw = 4'd2; Opcode_sw = OP_ADD; chain_en = 0;
    go_btn = 1'b1;
    wait_pulse(seen);
    chk("clr_go_pulse_seen", 32'(seen), 32'd1);
    tick();
    model_clear();
    chk("clr_go_busy", 32'(busy), 32'd0);
    chk("clr_go_alu_clr", 32'(alu_clr), 32'd1);
    chk("clr_go_rv", 32'(result_valid), 32'd0);
    go_btn = 1'b0; clear_btn = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    check_held("clr_go_after");

    // 6: reset for one edge in mid-EXEC
    A_sw = 4'd2; B_sw = 4'd3; Opcode_sw = OP_OR;
    go_btn = 1'b1;
    wait_pulse(seen);
    chk("rst_go_pulse_seen", 32'(seen), 32'd1);
    tick();
    chk("rst_exec_busy", 32'(busy), 32'd1);
    reset = 1'b0; go_btn = 1'b0;
    tick();
    reset = 1'b1;
    m_disp = '0; m_dop = '0; m_acc_valid = 0; m_rv = 0; m_err = 0;
    check_reset_vals("midrst");
    for (int i = 0; i < 10; i++) tick();
    check_reset_vals("midrst_nolatch");
    do_op(4'd7, 4'd1, OP_AND, 0, 0);

    // random ops against the model
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 5) == 0) do_clear();
      do_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 5)), bit'($urandom_range(0, 1)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
